// File: rtl/clock_reset_gearbox_if.sv
// clock_reset_gearbox_if: slow SOC clock, its enable pulse and the SOC reset
interface clock_reset_gearbox_if;
    logic clk;
    logic clk_en;
    logic resetn;
    modport master (output clk, clk_en, resetn);
    modport slave  (input  clk, clk_en, resetn);
endinterface

// File: rtl/clock_reset_gearbox.sv
// clock_reset_gearbox: divides board CLK into the SOC clock and produces one clean debounced reset per button press
module clock_reset_gearbox #(
    parameter int SLOW          = 21,
    parameter int DEBOUNCE_BITS = 16,
    parameter int HOLD          = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    clock_reset_gearbox_if.master  bus
);
    localparam int HW = $clog2(HOLD) + 1;

    typedef enum logic [1:0] {S_ASSERT, S_DEBOUNCE, S_HOLD, S_RUN} state_t;

    state_t                   state, state_n;
    logic [DEBOUNCE_BITS-1:0] deb, deb_n;
    logic [HW-1:0]            hold, hold_n;
    logic [1:0]               sync;
    logic                     synced;
    logic                     clk_en;
    logic                     resetn_q;

    generate
        if (SLOW == 0) begin : g_bypass
            assign bus.clk = CLK;
            assign clk_en  = 1'b1;
        end else begin : g_div
            logic [SLOW-1:0] div;
            // free-running divider; the top bit is the slow clock and the all-ones decode is the enable
            always_ff @(posedge CLK or negedge RESET)
                if (!RESET) div <= '0;
                else        div <= div + 1'b1;
            assign bus.clk = div[SLOW-1];
            assign clk_en  = &div;
        end
    endgenerate

    assign synced     = sync[1];
    assign bus.clk_en = clk_en;
    assign bus.resetn = resetn_q;

    // next-state: wait for the synchronised release, debounce it, then hold for a few slow periods
    always_comb begin
        state_n = state;
        deb_n   = deb;
        hold_n  = hold;
        case (state)
            S_ASSERT: if (synced) begin
                state_n = S_DEBOUNCE;
                deb_n   = '0;
            end
            S_DEBOUNCE: begin
                deb_n = deb + 1'b1;
                if (deb_n == '1) begin
                    state_n = S_HOLD;
                    hold_n  = '0;
                end
            end
            S_HOLD: if (clk_en) begin
                hold_n = hold + 1'b1;
                if (hold == HW'(HOLD - 1)) state_n = S_RUN;
            end
            default: ;
        endcase
    end

    // any low level on RESET clears everything at once; resetn only rises on an enable edge (slow clk falling)
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            sync     <= '0;
            state    <= S_ASSERT;
            deb      <= '0;
            hold     <= '0;
            resetn_q <= 1'b0;
        end else begin
            sync     <= {sync[0], 1'b1};
            state    <= state_n;
            deb      <= deb_n;
            hold     <= hold_n;
            resetn_q <= (state_n == S_RUN);
        end
endmodule

// File: tb/tb_clock_reset_gearbox.sv
// tb_clock_reset_gearbox: randomized release/glitch sequences checked against an edge-count model
module tb_clock_reset_gearbox;
    localparam int DB   = 3;
    localparam int HOLD = 2;
    localparam int P    = 8;
    localparam int D    = 2 + 2 ** DB;
    localparam int RS   = ((D / P) + 1) * P + (HOLD - 1) * P;
    localparam int RB   = (D + 1) + (HOLD - 1);

    logic CLK = 1'b0;
    logic RESET;
    int   n = 0;
    int   vectors = 0;
    int   errors = 0;

    clock_reset_gearbox_if s_if ();
    clock_reset_gearbox_if b_if ();

    clock_reset_gearbox #(.SLOW(3), .DEBOUNCE_BITS(DB), .HOLD(HOLD)) u_slow (.CLK(CLK), .RESET(RESET), .bus(s_if));
    clock_reset_gearbox #(.SLOW(0), .DEBOUNCE_BITS(DB), .HOLD(HOLD)) u_byp  (.CLK(CLK), .RESET(RESET), .bus(b_if));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    task automatic check_all();
        if (!RESET) begin
            chk("rst_clk", s_if.clk, 1'b0);
            chk("rst_clk_en", s_if.clk_en, 1'b0);
            chk("rst_resetn", s_if.resetn, 1'b0);
            chk("rst_byp_resetn", b_if.resetn, 1'b0);
        end else begin
            chk("clk", s_if.clk, logic'((n % P) >= P / 2));
            chk("clk_en", s_if.clk_en, logic'((n % P) == P - 1));
            chk("resetn", s_if.resetn, logic'(n >= RS));
            chk("byp_clk_lo", b_if.clk, 1'b0);
            chk("byp_clk_en", b_if.clk_en, 1'b1);
            chk("byp_resetn", b_if.resetn, logic'(n >= RB));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RESET) n++;
        #1;
        if (RESET) chk("byp_clk_hi", b_if.clk, 1'b1);
        @(negedge CLK);
        check_all();
    endtask

    task automatic release_btn();
        RESET = 1'b1;
        n = 0;
    endtask

    task automatic mid_cycle_drop(input bit sub_cycle);
        #2 RESET = 1'b0;
        #1;
        chk("async_resetn", s_if.resetn, 1'b0);
        chk("async_clk", s_if.clk, 1'b0);
        chk("async_clk_en", s_if.clk_en, 1'b0);
        chk("async_byp_resetn", b_if.resetn, 1'b0);
        if (sub_cycle) begin
            #1 release_btn();
        end
    endtask

    initial begin
        RESET = 1'b1;
        #1 RESET = 1'b0;
        repeat (5) tick();
        release_btn();
        repeat (40) tick();
        repeat (5) tick();
        release_btn();
        mid_cycle_drop(1'b0);
        @(negedge CLK);
        release_btn();
        repeat (5) tick();
        RESET = 1'b0;
        tick();
        release_btn();
        repeat (30) tick();
        mid_cycle_drop(1'b1);
        repeat (30) tick();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(3, 50)) tick();
            if ($urandom_range(0, 1) == 1) begin
                mid_cycle_drop(1'b1);
            end else begin
                mid_cycle_drop(1'b0);
                repeat ($urandom_range(1, 3)) tick();
                release_btn();
            end
        end
        repeat (30) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
